// File: rtl/adat_frame_reader.sv
// Read side of channel_buffer. It follows frames committed by adat_decoder, pulls each
// channel bit-serially out of the buffer RAM and presents 24-bit samples on valid/ready.
module adat_frame_reader #(
   parameter int CIRC_BUF_BITS = 3,
   parameter int LAG_LIMIT     = 6
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       has_sync_i,
   input  logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_i,
   output logic [CIRC_BUF_BITS+7:0]   read_addr_o,
   input  logic                       read_data_i,
   output logic [23:0]                sample_data_o,
   output logic [2:0]                 sample_channel_o,
   output logic                       sample_valid_o,
   input  logic                       sample_ready_i,
   output logic                       frame_start_o,
   output logic                       overrun_o
);

   localparam int AW = CIRC_BUF_BITS + 8;
   localparam logic [CIRC_BUF_BITS-1:0] LAG = CIRC_BUF_BITS'(LAG_LIMIT);
   localparam logic [CIRC_BUF_BITS-1:0] ONE = CIRC_BUF_BITS'(1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH, S_PRESENT} state_t;

   state_t                   r_state, w_state;
   logic [CIRC_BUF_BITS-1:0] r_rd_ptr, w_rd_ptr;
   logic [CIRC_BUF_BITS-1:0] r_cur, w_cur;
   logic [2:0]               r_ch, w_ch;
   logic [4:0]               r_bit, w_bit;
   logic [23:0]              r_shift, w_shift;
   logic [AW-1:0]            r_addr, w_addr;
   logic [23:0]              r_data, w_data;
   logic [2:0]               r_chan, w_chan;
   logic                     r_valid, w_valid;
   logic                     r_fs, w_fs;
   logic                     r_ovr, w_ovr;

   logic [CIRC_BUF_BITS-1:0] w_pending;
   logic [CIRC_BUF_BITS-1:0] w_seed;
   logic [CIRC_BUF_BITS-1:0] w_next_frame;

   assign w_pending    = last_good_frame_idx_i - r_rd_ptr;
   assign w_seed       = last_good_frame_idx_i - ONE;
   assign w_next_frame = r_rd_ptr + ONE;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state  <= S_IDLE;
         r_rd_ptr <= '0;
         r_cur    <= '0;
         r_ch     <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_addr   <= '0;
         r_data   <= '0;
         r_chan   <= '0;
         r_valid  <= 1'b0;
         r_fs     <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_rd_ptr <= w_rd_ptr;
         r_cur    <= w_cur;
         r_ch     <= w_ch;
         r_bit    <= w_bit;
         r_shift  <= w_shift;
         r_addr   <= w_addr;
         r_data   <= w_data;
         r_chan   <= w_chan;
         r_valid  <= w_valid;
         r_fs     <= w_fs;
         r_ovr    <= w_ovr;
      end
   end

   always_comb begin
      w_state  = r_state;
      w_rd_ptr = r_rd_ptr;
      w_cur    = r_cur;
      w_ch     = r_ch;
      w_bit    = r_bit;
      w_shift  = r_shift;
      w_addr   = r_addr;
      w_data   = r_data;
      w_chan   = r_chan;
      w_valid  = r_valid;
      w_fs     = 1'b0;
      w_ovr    = 1'b0;

      // Sync loss abandons any partial frame; the pointer is re-seeded on reacquire.
      if (!has_sync_i) begin
         w_state = S_IDLE;
         w_valid = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_rd_ptr = w_seed;
               w_state  = S_WAIT;
            end
            S_WAIT: begin
               if (w_pending > LAG) begin
                  w_rd_ptr = w_seed;
                  w_ovr    = 1'b1;
               end else if (w_pending != '0) begin
                  w_cur   = w_next_frame;
                  w_ch    = 3'd0;
                  w_bit   = 5'd0;
                  w_addr  = {w_next_frame, 3'd0, 5'd0};
                  w_fs    = 1'b1;
                  w_state = S_FETCH;
               end
            end
            S_FETCH: begin
               // r_bit counts FETCH cycles; RAM data lags the address by one.
               if (r_bit != 5'd0)
                  w_shift = {r_shift[22:0], read_data_i};
               if (r_bit == 5'd24) begin
                  w_data  = {r_shift[22:0], read_data_i};
                  w_chan  = r_ch;
                  w_valid = 1'b1;
                  w_state = S_PRESENT;
               end else begin
                  w_bit = r_bit + 5'd1;
                  if (r_bit < 5'd23)
                     w_addr = {r_cur, r_ch, r_bit + 5'd1};
               end
            end
            S_PRESENT: begin
               if (sample_ready_i) begin
                  w_valid = 1'b0;
                  if (r_ch == 3'd7) begin
                     w_rd_ptr = r_cur;
                     w_state  = S_WAIT;
                  end else begin
                     w_ch    = r_ch + 3'd1;
                     w_bit   = 5'd0;
                     w_addr  = {r_cur, r_ch + 3'd1, 5'd0};
                     w_state = S_FETCH;
                  end
               end
            end
            default: w_state = S_IDLE;
         endcase
      end
   end

   assign read_addr_o      = r_addr;
   assign sample_data_o    = r_data;
   assign sample_channel_o = r_chan;
   assign sample_valid_o   = r_valid;
   assign frame_start_o    = r_fs;
   assign overrun_o        = r_ovr;

endmodule
